// File: rtl/packet_assembler.sv
// -----------------------------------------------------------------------------
// packet_assembler
//
// Collects TLP and DLLP payload bytes from an upstream byte classifier into a
// local buffer. When a packet is framed correctly, the buffer is drained to a
// ready/valid downstream port with start/end-of-packet markers. Framing and
// length errors produce a one-cycle err pulse. A TLP ended by EDB produces a
// one-cycle nullified pulse. In both cases the packet is discarded.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   data_in[7:0]     classified byte
//   type_in[2:0]     byte class (data / tlp start,end,edb / dllp start,end / not valid)
//   valid_in         data_in/type_in qualified this cycle
//   out_data[7:0]    buffered payload byte
//   out_valid        out_data valid (draining)
//   out_ready        downstream accepts out_data this cycle
//   out_sop/out_eop  first / last payload byte of the packet
//   out_kind[1:0]    01 TLP, 10 DLLP, 00 idle
//   out_len[5:0]     payload length of the packet being drained
//   busy             draining; upstream bytes are dropped
//   err              one-cycle framing/length error pulse
//   nullified        one-cycle pulse when a TLP is ended by EDB
// -----------------------------------------------------------------------------
module packet_assembler #(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic [2:0] type_in,
  input  logic       valid_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_kind,
  output logic [5:0] out_len,
  output logic       busy,
  output logic       err,
  output logic       nullified
);

  localparam logic [2:0] T_DATA      = 3'b000;
  localparam logic [2:0] T_TLPSTART  = 3'b001;
  localparam logic [2:0] T_TLPEND    = 3'b010;
  localparam logic [2:0] T_DLLPSTART = 3'b011;
  localparam logic [2:0] T_DLLPEND   = 3'b100;
  localparam logic [2:0] T_TLPEDB    = 3'b101;

  localparam logic [1:0] KIND_TLP  = 2'b01;
  localparam logic [1:0] KIND_DLLP = 2'b10;

  localparam int         AW       = $clog2(MAX_LEN);
  localparam logic [5:0] MAX_CNT  = 6'(MAX_LEN);
  localparam logic [5:0] DLLP_LEN = 6'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COL_TLP,
    S_COL_DLLP,
    S_DRAIN
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [5:0] rd_ptr_q, rd_ptr_d;
  logic [5:0] len_q, len_d;
  logic [1:0] kind_q, kind_d;
  logic       err_q, err_d;
  logic       nullified_q, nullified_d;
  logic       wr_en;
  logic       draining;

  logic [7:0] buf_mem [MAX_LEN];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    kind_d      = kind_q;
    err_d       = 1'b0;
    nullified_d = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (type_in == T_TLPSTART) begin
            state_d = S_COL_TLP;
            count_d = '0;
            kind_d  = KIND_TLP;
          end else if (type_in == T_DLLPSTART) begin
            state_d = S_COL_DLLP;
            count_d = '0;
            kind_d  = KIND_DLLP;
          end
        end
      end

      S_COL_TLP, S_COL_DLLP: begin
        if (valid_in) begin
          unique case (type_in)
            T_DATA: begin
              if (count_q == MAX_CNT) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end else begin
                wr_en   = 1'b1;
                count_d = count_q + 6'd1;
              end
            end
            // A new start aborts the current packet and opens a fresh one.
            T_TLPSTART: begin
              err_d   = 1'b1;
              state_d = S_COL_TLP;
              count_d = '0;
              kind_d  = KIND_TLP;
            end
            T_DLLPSTART: begin
              err_d   = 1'b1;
              state_d = S_COL_DLLP;
              count_d = '0;
              kind_d  = KIND_DLLP;
            end
            T_TLPEND: begin
              if (state_q == S_COL_TLP && count_q != 6'd0) begin
                len_d    = count_q;
                rd_ptr_d = '0;
                state_d  = S_DRAIN;
              end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
            end
            T_DLLPEND: begin
              if (state_q == S_COL_DLLP && count_q == DLLP_LEN) begin
                len_d    = DLLP_LEN;
                rd_ptr_d = '0;
                state_d  = S_DRAIN;
              end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
            end
            T_TLPEDB: begin
              if (state_q == S_COL_TLP) nullified_d = 1'b1;
              else                      err_d       = 1'b1;
              state_d = S_IDLE;
            end
            // Covers not_valid (111) and the unused code 110.
            default: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end

      S_DRAIN: begin
        // Incoming bytes are dropped. A start symbol here means a whole
        // packet has been lost, so it is flagged.
        if (valid_in && (type_in == T_TLPSTART || type_in == T_DLLPSTART)) begin
          err_d = 1'b1;
        end
        if (out_ready) begin
          if (rd_ptr_q == len_q - 6'd1) begin
            rd_ptr_d = '0;
            state_d  = S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 6'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      kind_q      <= '0;
      err_q       <= 1'b0;
      nullified_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      kind_q      <= kind_d;
      err_q       <= err_d;
      nullified_q <= nullified_d;
    end
  end

  // NOTE: the payload buffer has no reset. Its contents are only read after
  // being written for the current packet, and leaving the reset off lets it
  // map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[count_q[AW-1:0]] <= data_in;
  end

  // ---------------------------------------------------------------------------
  // Outputs: derived from registered state, so they are zero as soon as reset
  // asserts and remain stable while the downstream stalls.
  // ---------------------------------------------------------------------------
  assign draining  = (state_q == S_DRAIN);
  assign out_valid = draining;
  assign busy      = draining;
  assign out_data  = draining ? buf_mem[rd_ptr_q[AW-1:0]] : 8'h00;
  assign out_sop   = draining && (rd_ptr_q == 6'd0);
  assign out_eop   = draining && (rd_ptr_q == len_q - 6'd1);
  assign out_kind  = draining ? kind_q : 2'b00;
  assign out_len   = draining ? len_q : 6'd0;
  assign err       = err_q;
  assign nullified = nullified_q;

endmodule
